// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES : bytes per stored word
//   ADDR_LSB   : byte-address bits below the word index
//   CNT_W      : width of the wait-state counter (WAIT_CYCLES <= 15)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write with per-byte strobes,
// combinational read of the indexed word.
// Ports:
//   clk   : clock, writes on rising edge
//   we    : write enable
//   be    : byte-lane strobes, lane i = bits 8i+7:8i
//   idx   : word index (shared by read and write)
//   wdata : write data
//   rdata : word currently at idx
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; contents survive a reset and a
  // reset loop over every word would not map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port. Accepts one
// load/store over a valid/ready handshake, waits WAIT_CYCLES states, accesses
// the word storage and holds the response until the initiator takes it.
// Optional feature: define DMEM_BYTE_ENABLE_EN to add req_be byte strobes;
// without it every store writes the whole word.
// Ports:
//   clk, reset            : core clock, synchronous active-low reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata (, req_be) : request, latched on acceptance
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [WORD_BYTES-1:0] req_be,
`endif
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    lat_we;
  logic [31:0]             lat_addr;
  logic [31:0]             lat_wdata;

  // With zero wait states the access happens on the accepting edge, so the
  // access path reads the live request in IDLE and the latched copy later.
  logic                    acc_we;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic [WORD_BYTES-1:0]   acc_be;
  logic                    do_access;
  logic                    acc_err;
  logic                    mem_we;
  logic [31:0]             mem_rdata;
  logic [31:0]             load_data;

  assign acc_we    = (state == IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

`ifdef DMEM_BYTE_ENABLE_EN
  logic [WORD_BYTES-1:0] lat_be;
  assign acc_be = (state == IDLE) ? req_be : lat_be;
`else
  assign acc_be = '1;
`endif

  assign do_access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == '0));

  // Misaligned, or any address bit above the word index set.
  assign acc_err = (|acc_addr[ADDR_LSB-1:0]) |
                   (|(acc_addr >> (IDX_W + ADDR_LSB)));

  // Reset wins over an access scheduled on the same edge.
  assign mem_we    = do_access && acc_we && !acc_err && reset;
  assign load_data = (acc_we || acc_err) ? 32'h0 : mem_rdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (acc_be),
    .idx   (acc_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // NOTE: the latched request fields are plain datapath registers and are
  // deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
            lat_be    <= req_be;
`endif
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= acc_err;
              rsp_rdata <= load_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances share the clock and
// reset: u_dut_a with WAIT_CYCLES=2 and u_dut_b with WAIT_CYCLES=0; sel picks
// which one the request/response tasks drive and observe.
module tb_dmem_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
  logic [3:0]  req_be = 4'hF;
`endif

  logic        rdy [2];
  logic        vld [2];
  logic        err [2];
  logic [31:0] rdat [2];
  logic        rv_a, rv_b;

  assign rv_a = req_valid && !sel;
  assign rv_b = req_valid && sel;

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? rdy[1]  : rdy[0];
  assign cur_valid = sel ? vld[1]  : vld[0];
  assign cur_err   = sel ? err[1]  : err[0];
  assign cur_rdata = sel ? rdat[1] : rdat[0];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv_a),
    .req_ready (rdy[0]),
    .req_we    (req_we),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be    (req_be),
`endif
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (vld[0]),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rdat[0]),
    .rsp_err   (err[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv_b),
    .req_ready (rdy[1]),
    .req_we    (req_we),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be    (req_be),
`endif
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (vld[1]),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rdat[1]),
    .rsp_err   (err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t exp_q [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic scramble();
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Wait for req_ready, present one request, return at the negedge after the
  // accepting edge. The expected response is queued when push is set.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic push);
    int n = 0;
    while (!cur_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) check("req_ready_timeout", 32'(n), 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef DMEM_BYTE_ENABLE_EN
    req_be    = be;
`else
    if (be != 4'hF) $display("note: byte enables ignored in this build");
`endif
    if (push) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
  endtask

  // Wait for the response, check its latency and contents against the
  // scoreboard, optionally hold off rsp_ready, then complete the handshake.
  task automatic get_rsp(input string name, input int hold);
    int   lat = 1;
    int   exp_lat;
    exp_t e;
    exp_lat = (sel ? W_B : W_A) + 1;
    while (!cur_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      check({name, "_hold_valid"}, 32'(cur_valid), 32'd1);
      check({name, "_hold_rdata"}, cur_rdata, e.rdata);
      check({name, "_hold_req_ready"}, 32'(cur_ready), 32'd0);
      scramble();
      @(negedge clk);
    end
    check({name, "_rdata"}, cur_rdata, e.rdata);
    check({name, "_err"}, 32'(cur_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_valid_cleared"}, 32'(cur_valid), 32'd0);
    check({name, "_req_ready_after"}, 32'(cur_ready), 32'd1);
  endtask

  vec_t vecs [13];

  initial begin
    logic seen;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0055, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0100, 32'hCCCC_CCCC, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0055, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h0000_0101, 32'h0,         32'h0,         1'b1};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset_req_ready_a", 32'(rdy[0]), 32'd1);
    check("reset_rsp_valid_a", 32'(vld[0]), 32'd0);
    check("reset_rsp_err_a",   32'(err[0]), 32'd0);
    check("reset_rsp_rdata_a", rdat[0],     32'd0);
    check("reset_req_ready_b", 32'(rdy[1]), 32'd1);
    check("reset_rsp_valid_b", 32'(vld[1]), 32'd0);

    // Table-driven transactions on the WAIT_CYCLES=2 instance.
    sel = 1'b0;
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF, vecs[i].rdata, vecs[i].err, 1'b1);
      get_rsp($sformatf("vec%0d", i), 0);
    end

    // Response backpressure: load held for 5 cycles with rsp_ready low.
    send(1'b1, 32'h20, 32'h0000_0077, 4'hF, 32'h0, 1'b0, 1'b1);
    get_rsp("store_20", 0);
    send(1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_0077, 1'b0, 1'b1);
    get_rsp("backpressure", 5);

    // Reset mid-WAIT: the store is dropped and the old word survives.
    send(1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("midwait_req_ready", 32'(cur_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen |= cur_valid;
      @(negedge clk);
    end
    check("midwait_no_rsp", 32'(seen), 32'd0);
    send(1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_0077, 1'b0, 1'b1);
    get_rsp("midwait_readback", 0);

    // Reset coincident with acceptance: the request is lost.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h9999_9999;
    reset     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen |= cur_valid;
      @(negedge clk);
    end
    check("reset_accept_no_rsp", 32'(seen), 32'd0);
    send(1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_0077, 1'b0, 1'b1);
    get_rsp("reset_accept_readback", 0);

`ifdef DMEM_BYTE_ENABLE_EN
    // Byte-lane stores.
    send(1'b1, 32'h30, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b1);
    get_rsp("be_clear", 0);
    send(1'b1, 32'h30, 32'hCAFE_BABE, 4'b0101, 32'h0, 1'b0, 1'b1);
    get_rsp("be_0101", 0);
    send(1'b0, 32'h30, 32'h0, 4'b0000, 32'h00FE_00BE, 1'b0, 1'b1);
    get_rsp("be_readback", 0);
    send(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
    get_rsp("be_noop", 0);
    send(1'b0, 32'h30, 32'h0, 4'hF, 32'h00FE_00BE, 1'b0, 1'b1);
    get_rsp("be_noop_readback", 0);
`endif

    // Zero wait states on the second instance.
    sel = 1'b1;
    @(negedge clk);
    send(1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);
    get_rsp("zero_store", 0);
    send(1'b0, 32'h0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    get_rsp("zero_load", 0);
    send(1'b0, 32'h6, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
    get_rsp("zero_misaligned", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- The core issues load/store requests: address from the ALU result, store data from rs2, write enable from the control unit. This block accepts each request over a valid/ready handshake and inserts a programmable number of wait states.
- It performs the word access on internal storage and returns read data or an error over a held response handshake.
- Sits between the core's load/store path and the result mux; clocked by the same divided core clock.

Parameters:
- DEPTH, 64, number of 32-bit words stored; must be a power of two, at most 2^30.
- WAIT_CYCLES, 2, wait states between request acceptance and the access; range 0..15.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- FSM states are IDLE, WAIT and RESP. Reset (reset==0 at an edge) forces IDLE.
- Reset clears rsp_valid, rsp_err, rsp_rdata and the wait counter, and sets req_ready=1. Storage contents are not cleared.
- req_ready is 1 only in IDLE.
- Acceptance: req_valid & req_ready at an edge latches we, addr and wdata.
  - If WAIT_CYCLES==0, the next state is RESP and the access happens on that same edge.
  - Otherwise the next state is WAIT with counter = WAIT_CYCLES-1.
- WAIT: the counter decrements each edge. When the counter is 0, the access happens on that edge and the next state is RESP.
- The block spends exactly WAIT_CYCLES cycles in WAIT. rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
- Access:
  - Word index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0]!=0 or addr[31:log2(DEPTH)+2]!=0. On error: no write, rsp_err=1, rsp_rdata=0.
  - Valid store: the word is written; rsp_rdata=0, rsp_err=0.
  - Valid load: rsp_rdata = stored word, rsp_err=0.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready the next state is IDLE and rsp_valid clears on that edge.
  - A new request can be accepted no earlier than the edge after the handshake. There is no back-to-back overlap.
- Inputs req_we, req_addr and req_wdata are ignored outside the accepting edge. Changing them during WAIT or RESP has no effect.
- Reset mid-WAIT: the pending access is dropped and storage is unmodified. Reset mid-RESP: the response is discarded.
- Reset asserted coincident with acceptance: reset wins and the request is lost.
- Write and read of the same word never overlap, since there is a single outstanding request.

Optional Feature:
- Macro: DMEM_BYTE_ENABLE_EN.
- Defined: adds input req_be[3:0], latched at acceptance. A store writes only the bytes whose be bit is 1; lane i corresponds to bits 8i+7:8i. A store with be=0000 is a valid no-op (rsp_err=0). Loads ignore be.
- Undefined: the port is absent and every store writes all 4 bytes.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - WORD_BYTES=4 and ADDR_LSB=2;
  - the wait-counter width constant (4 bits).
- One sub-module, dmem_array: synchronous-write word storage.
  - Combinational read of the indexed word.
  - Per-byte write strobes, tied to 1111 when DMEM_BYTE_ENABLE_EN is undefined.
- The FSM, counter and error check live in dmem_responder.

Test Plan:
- Basic store then load: after reset with WAIT_CYCLES=2, store 0xDEADBEEF to 0x10, then load 0x10.
  - The store's rsp_valid rises 3 cycles after acceptance with err=0.
  - The load returns rdata=0xDEADBEEF, err=0.
- Zero latency: with WAIT_CYCLES=0, store 0x12345678 to 0x0, then load 0x0. rsp_valid is high on the cycle after acceptance and the load returns 0x12345678.
- Misaligned address: load 0x6 returns err=1, rdata=0. A store of 0xFFFFFFFF to 0x6 with err=1 leaves word 0x4 unchanged on readback.
- Out-of-range address: with DEPTH=64, store to 0x100 gives err=1. A subsequent load of 0x0 is unaffected.
- Response backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid stays 1, rdata is stable and req_ready stays 0 throughout. After rsp_ready=1, req_ready=1 the next cycle.
- Reset mid-WAIT and byte enables: pulse reset=0 during the WAIT of a store of 0xAAAAAAAA to 0x20. The FSM returns to IDLE and the old contents of 0x20 are retained. With DMEM_BYTE_ENABLE_EN, store 0xCAFEBABE with be=0101 over 0x00000000; the readback is 0x00FE00BE.
